// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 320x480 raster geometry and counter-width helper.
package vga_timing_pkg;
    localparam int DEF_H_ACTIVE = 320;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BP     = 24;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int clog2_total(input int active, input int fp, input int sync, input int bp);
        return $clog2(active + fp + sync + bp);
    endfunction
endpackage

// File: rtl/vga_timing_gen_axis.sv
// timing_axis_cntr: one raster axis; count register plus sync/blank decoded from the next count.
module timing_axis_cntr
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0,
    localparam int W     = clog2_total(ACTIVE, FP, SYNC, BP)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         step_en,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync,
    output logic         blank
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    // Every boundary is below TOTAL, so it fits the W-bit count exactly.
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] BLANK_LO = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad
        $error("timing_axis_cntr: ACTIVE, FP, SYNC and BP must all be nonzero");
    end

    logic [W-1:0] next_count;

    always_comb begin
        wrap       = step_en && count == LAST;
        next_count = wrap ? '0 : step_en ? count + W'(1) : count;
        blank      = next_count >= BLANK_LO;
        sync       = (next_count >= SYNC_LO && next_count < SYNC_HI) ? POL : ~POL;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset)
            count <= '0;
        else
            count <= next_count;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing; h/v axis counters with registered sync, blank, active and strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    localparam int HW       = clog2_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int VW       = clog2_total(V_ACTIVE, V_FP, V_SYNC, V_BP)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          active,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic h_wrap, h_sync, h_blank, v_wrap, v_sync, v_blank;

    timing_axis_cntr #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)) u_h (
        .clock(clock), .reset(reset), .step_en(pix_en),
        .count(pixel_x), .wrap(h_wrap), .sync(h_sync), .blank(h_blank)
    );

    timing_axis_cntr #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)) u_v (
        .clock(clock), .reset(reset), .step_en(pix_en & h_wrap),
        .count(pixel_y), .wrap(v_wrap), .sync(v_sync), .blank(v_blank)
    );

    // An h-wrap forces a v-step, so next_y == 0 on an h-wrap exactly when v wraps.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
            active      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= h_sync;
            vsync       <= v_sync;
            hblank      <= h_blank;
            vblank      <= v_blank;
            active      <= ~h_blank & ~v_blank;
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for the default geometry and a small 8x6 positive-sync build.
module tb_vga_timing_gen;
    typedef struct {int x, y, hs, vs, hb, vb, ac, ls, fs;} exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst0, en0, rst1, en1;
    logic hs0, vs0, hb0, vb0, ac0, ls0, fs0, hs1, vs1, hb1, vb1, ac1, ls1, fs1;
    logic [8:0] x0;
    logic [9:0] y0;
    logic [2:0] x1, y1;

    vga_timing_gen u0 (
        .clock(clock), .reset(rst0), .pix_en(en0), .hsync(hs0), .vsync(vs0), .hblank(hb0),
        .vblank(vb0), .active(ac0), .pixel_x(x0), .pixel_y(y0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) u1 (
        .clock(clock), .reset(rst1), .pix_en(en1), .hsync(hs1), .vsync(vs1), .hblank(hb1),
        .vblank(vb1), .active(ac1), .pixel_x(x1), .pixel_y(y1), .line_start(ls1), .frame_start(fs1)
    );

    int checks = 0, failures = 0;
    exp_t q0[$], q1[$];
    int mx0 = 0, my0 = 0, mx1 = 0, my1 = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t decode(input int x, input int y, input bit ls, input int ha, input int hf,
                                    input int hw, input int va, input int vf, input int vw,
                                    input bit hp, input bit vp);
        exp_t e;
        e.x  = x;
        e.y  = y;
        e.hb = (x >= ha) ? 1 : 0;
        e.vb = (y >= va) ? 1 : 0;
        e.ac = (e.hb == 0 && e.vb == 0) ? 1 : 0;
        e.hs = (x >= ha + hf && x < ha + hf + hw) ? int'(hp) : int'(!hp);
        e.vs = (y >= va + vf && y < va + vf + vw) ? int'(vp) : int'(!vp);
        e.ls = ls ? 1 : 0;
        e.fs = (ls && y == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic step0(input bit e);
        @(negedge clock);
        en0 = e;
        if (e) begin
            mx0 = (mx0 == 399) ? 0 : mx0 + 1;
            if (mx0 == 0) my0 = (my0 == 524) ? 0 : my0 + 1;
        end
        q0.push_back(decode(mx0, my0, e && mx0 == 0, 320, 8, 48, 480, 10, 2, 1'b0, 1'b0));
        @(posedge clock);
        #1;
    endtask

    task automatic step1(input bit e);
        @(negedge clock);
        en1 = e;
        if (e) begin
            mx1 = (mx1 == 7) ? 0 : mx1 + 1;
            if (mx1 == 0) my1 = (my1 == 5) ? 0 : my1 + 1;
        end
        q1.push_back(decode(mx1, my1, e && mx1 == 0, 4, 1, 2, 3, 1, 1, 1'b1, 1'b1));
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset0(input string t);
        chk({t, ".x"}, int'(x0), 0);
        chk({t, ".y"}, int'(y0), 0);
        chk({t, ".hsync"}, int'(hs0), 1);
        chk({t, ".vsync"}, int'(vs0), 1);
        chk({t, ".hblank"}, int'(hb0), 0);
        chk({t, ".vblank"}, int'(vb0), 0);
        chk({t, ".active"}, int'(ac0), 1);
        chk({t, ".line_start"}, int'(ls0), 0);
        chk({t, ".frame_start"}, int'(fs0), 0);
    endtask

    task automatic chk_reset1(input string t);
        chk({t, ".x"}, int'(x1), 0);
        chk({t, ".y"}, int'(y1), 0);
        chk({t, ".hsync"}, int'(hs1), 0);
        chk({t, ".vsync"}, int'(vs1), 0);
        chk({t, ".hblank"}, int'(hb1), 0);
        chk({t, ".vblank"}, int'(vb1), 0);
        chk({t, ".active"}, int'(ac1), 1);
        chk({t, ".line_start"}, int'(ls1), 0);
        chk({t, ".frame_start"}, int'(fs1), 0);
    endtask

    task automatic cmp(input string t, input exp_t e, input int x, input int y, input int hs, input int vs,
                       input int hb, input int vb, input int ac, input int ls, input int fs);
        chk({t, ".x"}, x, e.x);
        chk({t, ".y"}, y, e.y);
        chk({t, ".hsync"}, hs, e.hs);
        chk({t, ".vsync"}, vs, e.vs);
        chk({t, ".hblank"}, hb, e.hb);
        chk({t, ".vblank"}, vb, e.vb);
        chk({t, ".active"}, ac, e.ac);
        chk({t, ".line_start"}, ls, e.ls);
        chk({t, ".frame_start"}, fs, e.fs);
    endtask

    // Monitor: runs after each edge, after stimulus has sampled, and scores whatever is queued.
    always @(posedge clock) begin : monitor
        exp_t e;
        #2;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("sb0", e, int'(x0), int'(y0), int'(hs0), int'(vs0), int'(hb0), int'(vb0), int'(ac0),
                int'(ls0), int'(fs0));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("sb1", e, int'(x1), int'(y1), int'(hs1), int'(vs1), int'(hb1), int'(vb1), int'(ac1),
                int'(ls1), int'(fs1));
        end
    end

    initial begin
        int hb_x, hs_first, hs_last, hs_cnt, ls_cnt, ls_x, ls_i, strobe_off, fs_cnt;
        rst0 = 1'b1;
        rst1 = 1'b1;
        en0  = 1'b0;
        en1  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_reset0("rst0");
        chk_reset1("rst1");
        @(negedge clock);
        rst0 = 1'b0;
        rst1 = 1'b0;

        hb_x = -1; hs_first = -1; hs_last = -1; hs_cnt = 0; ls_cnt = 0; ls_x = -1;
        for (int i = 0; i < 400; i++) begin
            step0(1'b1);
            if (i == 0) chk("first_step.x", int'(x0), 1);
            if (hb0 && hb_x < 0) hb_x = int'(x0);
            if (!hs0) begin
                if (hs_first < 0) hs_first = int'(x0);
                hs_last = int'(x0);
                hs_cnt++;
            end
            if (ls0) begin
                ls_cnt++;
                ls_x = int'(x0);
            end
        end
        chk("line.hblank_rise_x", hb_x, 320);
        chk("line.hsync_first_x", hs_first, 328);
        chk("line.hsync_last_x", hs_last, 375);
        chk("line.hsync_width", hs_cnt, 48);
        chk("line.line_starts", ls_cnt, 1);
        chk("line.line_start_x", ls_x, 0);
        chk("line.y", int'(y0), 1);

        ls_cnt = 0; ls_i = -1; strobe_off = 0;
        for (int i = 0; i < 800; i++) begin
            step0(i % 2 == 1);
            if (ls0) begin
                ls_cnt++;
                ls_i = i;
            end
            if (i % 2 == 0 && (ls0 || fs0)) strobe_off++;
        end
        chk("half.line_starts", ls_cnt, 1);
        chk("half.line_clock", ls_i, 799);
        chk("half.strobe_while_idle", strobe_off, 0);
        chk("half.x", int'(x0), 0);
        chk("half.y", int'(y0), 2);

        for (int i = 0; i < 350; i++) step0(1'b1);
        chk("mid0.x", int'(x0), 350);
        chk("mid0.hsync", int'(hs0), 0);
        chk("mid0.hblank", int'(hb0), 1);
        #3;
        rst0 = 1'b1;
        #1;
        chk_reset0("async0");
        mx0 = 0;
        my0 = 0;
        @(negedge clock);
        rst0 = 1'b0;

        fs_cnt = 0; ls_cnt = 0;
        for (int i = 0; i < 144; i++) begin
            step1(1'b1);
            if (fs1) fs_cnt++;
            if (ls1) ls_cnt++;
        end
        chk("frames.frame_starts", fs_cnt, 3);
        chk("frames.line_starts", ls_cnt, 18);
        chk("frames.x", int'(x1), 0);
        chk("frames.y", int'(y1), 0);

        for (int i = 0; i < 100; i++) step1(i % 3 != 0);
        #3;
        rst1 = 1'b1;
        #1;
        chk_reset1("async1a");
        mx1 = 0;
        my1 = 0;
        @(negedge clock);
        rst1 = 1'b0;

        for (int i = 0; i < 37; i++) step1(1'b1);
        chk("mid1.x", int'(x1), 5);
        chk("mid1.y", int'(y1), 4);
        chk("mid1.hsync", int'(hs1), 1);
        chk("mid1.vsync", int'(vs1), 1);
        chk("mid1.vblank", int'(vb1), 1);
        #3;
        rst1 = 1'b1;
        #1;
        chk_reset1("async1b");
        @(negedge clock);
        rst1 = 1'b0;

        repeat (3) @(posedge clock);
        #3;
        chk("drain.q0", q0.size(), 0);
        chk("drain.q1", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
